// File: rtl/mul_float_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul_float_rr_arbiter                                       |
// | Description : Round-robin front end that lets NUM_REQ requesters share   |
// |               one combinational single-precision multiplier. The        |
// |               winner's operands are steered to the multiplier and the    |
// |               product is captured, with the winner's index, into a       |
// |               one-entry output register.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         rising-edge clock                                          |
// |   rst_n       synchronous active-low reset                               |
// |   req_valid   per-requester operand valid                                |
// |   req_ready   per-requester accept, one-hot or zero (combinational)      |
// |   req_a/b     operands, requester i at bits [32*i+31:32*i]              |
// |   mul_a/b     operands to the shared multiplier (zero when no grant)     |
// |   mul_result  product returned by the multiplier (combinational)         |
// |   out_valid   output register holds a result                             |
// |   out_ready   downstream accepts the result                              |
// |   out_result  registered product                                         |
// |   out_id      index of the requester that produced out_result            |
// |   ops_count   completed output transactions, wraps at 2^32               |
// +--------------------------------------------------------------------------+

module mul_float_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [ID_W-1:0]       out_id,
  output logic [31:0]           ops_count
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

  logic                 r_out_valid;
  logic [31:0]          r_out_result;
  logic [ID_W-1:0]      r_out_id;
  logic [31:0]          r_ops_count;
  logic [ID_W-1:0]      r_ptr;

  logic                 w_slot_free;
  logic                 w_found;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [ID_W:0]        w_cand;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_xfer;
  logic                 w_drain;
  logic [ID_W-1:0]      w_ptr_next;
  logic [31:0]          w_mul_a;
  logic [31:0]          w_mul_b;

  // The register can take a new product if it is empty or is being drained
  // in this same cycle, which is what gives one product per clock.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_drain     = r_out_valid && out_ready;

  // Rotating priority search: first valid requester at or after r_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand >= c_num_req) begin
        w_cand = w_cand - c_num_req;
      end
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[ID_W-1:0];
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted into a register
  // that is being cleared on the same edge.
  always_comb begin
    w_grant = '0;
    if (rst_n && w_slot_free && w_found) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  // A grant is only ever raised on a valid requester, so any grant is a transfer.
  assign w_xfer = |w_grant;

  // AND-OR operand steering; zero when nothing is granted.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_mul_a = req_a[32*i +: 32];
        w_mul_b = req_b[32*i +: 32];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_id     <= '0;
      r_ops_count  <= '0;
      r_ptr        <= '0;
    end else begin
      if (w_drain) begin
        r_ops_count <= r_ops_count + 32'd1;
      end
      if (w_xfer) begin
        r_out_valid  <= 1'b1;
        r_out_result <= mul_result;
        r_out_id     <= w_gnt_idx;
        r_ptr        <= w_ptr_next;
      end else if (w_drain) begin
        // Result and id are left as-is; only the valid flag drops.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req_ready  = w_grant;
  assign mul_a      = w_mul_a;
  assign mul_b      = w_mul_b;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_id     = r_out_id;
  assign ops_count  = r_ops_count;

endmodule

`default_nettype wire
